// File: rtl/alu_pkg.sv
// Shared definitions for the ALU issue controller: word width,
// ALU op-codes and the issue FSM state encoding.
package alu_pkg;

    localparam int unsigned WORD_W = 32;

    typedef enum logic [3:0] {
        OP_ADD   = 4'd0,
        OP_SUB   = 4'd1,
        OP_AND   = 4'd2,
        OP_OR    = 4'd3,
        OP_XOR   = 4'd4,
        OP_NOT_A = 4'd5,
        OP_NOT_B = 4'd6
    } alu_op_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LO   = 2'd1,
        ST_HI   = 2'd2,
        ST_DONE = 2'd3
    } state_e;

    // Only add and sub propagate a carry/borrow between passes and to the result.
    function automatic logic op_has_carry(input logic [3:0] op);
        return (op == OP_ADD) || (op == OP_SUB);
    endfunction

endpackage

// File: rtl/alu_issue_ctrl.sv
// Issue controller for an external combinational 32-bit ALU: accepts one
// 32- or 64-bit command, sequences it through one or two ALU passes and
// holds the result until it is consumed.
module alu_issue_ctrl
    import alu_pkg::*;
#(
    parameter int unsigned CNT_W = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic [3:0]            cmd_op,
    input  logic                  cmd_wide,
    input  logic [2*WORD_W-1:0]   cmd_a,
    input  logic [2*WORD_W-1:0]   cmd_b,
    input  logic                  cmd_cin,
    output logic [WORD_W-1:0]     alu_a,
    output logic [WORD_W-1:0]     alu_b,
    output logic                  alu_cin,
    output logic [3:0]            alu_op,
    input  logic [WORD_W-1:0]     alu_result,
    input  logic                  alu_cout,
    output logic                  res_valid,
    input  logic                  res_ready,
    output logic [2*WORD_W-1:0]   res_data,
    output logic                  res_carry,
    output logic [CNT_W-1:0]      op_count
);

    state_e                state_q, state_d;
    logic [3:0]            op_q, op_d;
    logic                  wide_q, wide_d;
    logic [2*WORD_W-1:0]   a_q, a_d;
    logic [2*WORD_W-1:0]   b_q, b_d;
    logic                  cin_q, cin_d;
    logic                  carry_q, carry_d;
    logic [2*WORD_W-1:0]   res_data_q, res_data_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic                  cmd_ready_q, cmd_ready_d;
    logic                  res_valid_q, res_valid_d;

    // Next-state and datapath capture for the issue FSM.
    always_comb begin
        state_d    = state_q;
        op_d       = op_q;
        wide_d     = wide_q;
        a_d        = a_q;
        b_d        = b_q;
        cin_d      = cin_q;
        carry_d    = carry_q;
        res_data_d = res_data_q;
        cnt_d      = cnt_q;
        case (state_q)
            ST_IDLE: begin
                if (cmd_valid) begin
                    op_d    = cmd_op;
                    wide_d  = cmd_wide;
                    a_d     = cmd_a;
                    b_d     = cmd_b;
                    cin_d   = cmd_cin;
                    state_d = ST_LO;
                end
            end
            ST_LO: begin
                res_data_d = {{WORD_W{1'b0}}, alu_result};
                carry_d    = alu_cout;
                state_d    = wide_q ? ST_HI : ST_DONE;
            end
            ST_HI: begin
                res_data_d[2*WORD_W-1:WORD_W] = alu_result;
                carry_d                       = alu_cout;
                state_d                       = ST_DONE;
            end
            ST_DONE: begin
                if (res_ready) begin
                    cnt_d   = cnt_q + CNT_W'(1);
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
        // Handshake outputs are registered, so decode them from the next state.
        cmd_ready_d = (state_d == ST_IDLE);
        res_valid_d = (state_d == ST_DONE);
    end

    // ALU drive: low word in LO, high word with chained carry in HI, zero otherwise.
    always_comb begin
        alu_a   = '0;
        alu_b   = '0;
        alu_cin = 1'b0;
        alu_op  = '0;
        case (state_q)
            ST_LO: begin
                alu_a   = a_q[WORD_W-1:0];
                alu_b   = b_q[WORD_W-1:0];
                alu_cin = cin_q;
                alu_op  = op_q;
            end
            ST_HI: begin
                alu_a   = a_q[2*WORD_W-1:WORD_W];
                alu_b   = b_q[2*WORD_W-1:WORD_W];
                alu_cin = op_has_carry(op_q) & carry_q;
                alu_op  = op_q;
            end
            default: ;
        endcase
    end

    // State and datapath registers; reset discards any operation in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            op_q        <= '0;
            wide_q      <= 1'b0;
            a_q         <= '0;
            b_q         <= '0;
            cin_q       <= 1'b0;
            carry_q     <= 1'b0;
            res_data_q  <= '0;
            cnt_q       <= '0;
            cmd_ready_q <= 1'b1;
            res_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            op_q        <= op_d;
            wide_q      <= wide_d;
            a_q         <= a_d;
            b_q         <= b_d;
            cin_q       <= cin_d;
            carry_q     <= carry_d;
            res_data_q  <= res_data_d;
            cnt_q       <= cnt_d;
            cmd_ready_q <= cmd_ready_d;
            res_valid_q <= res_valid_d;
        end
    end

    assign cmd_ready = cmd_ready_q;
    assign res_valid = res_valid_q;
    assign res_data  = res_data_q;
    assign res_carry = op_has_carry(op_q) & carry_q;
    assign op_count  = cnt_q;

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Self-checking bench for alu_issue_ctrl with a behavioural 32-bit ALU
// beside it and a 64-bit reference model feeding a result scoreboard.
module tb_alu_issue_ctrl;

    localparam int unsigned CNT_W = 2;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             cmd_valid, cmd_ready, cmd_wide, cmd_cin;
    logic [3:0]       cmd_op;
    logic [63:0]      cmd_a, cmd_b;
    logic [31:0]      alu_a, alu_b, alu_result;
    logic             alu_cin, alu_cout;
    logic [3:0]       alu_op;
    logic             res_valid, res_ready, res_carry;
    logic [63:0]      res_data;
    logic [CNT_W-1:0] op_count;

    always #5 clk = ~clk;

    alu_issue_ctrl #(.CNT_W(CNT_W)) dut (
        .clk(clk), .rst_n(rst_n),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
        .cmd_wide(cmd_wide), .cmd_a(cmd_a), .cmd_b(cmd_b), .cmd_cin(cmd_cin),
        .alu_a(alu_a), .alu_b(alu_b), .alu_cin(alu_cin), .alu_op(alu_op),
        .alu_result(alu_result), .alu_cout(alu_cout),
        .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data),
        .res_carry(res_carry), .op_count(op_count)
    );

    // Behavioural combinational ALU the controller drives.
    logic [32:0] alu_s;
    always_comb begin
        case (alu_op)
            4'd0:    alu_s = {1'b0, alu_a} + {1'b0, alu_b} + {32'd0, alu_cin};
            4'd1:    alu_s = {1'b0, alu_a} - {1'b0, alu_b} - {32'd0, alu_cin};
            4'd2:    alu_s = {1'b0, alu_a & alu_b};
            4'd3:    alu_s = {1'b0, alu_a | alu_b};
            4'd4:    alu_s = {1'b0, alu_a ^ alu_b};
            4'd5:    alu_s = {1'b0, ~alu_a};
            4'd6:    alu_s = {1'b0, ~alu_b};
            default: alu_s = {1'b0, alu_a};
        endcase
    end
    assign alu_result = alu_s[31:0];
    assign alu_cout   = alu_s[32];

    typedef struct {
        logic [63:0] data;
        logic        carry;
    } exp_t;

    typedef struct {
        logic [63:0] data;
        logic        carry;
        int          lat;
        logic [31:0] lo_a;
        logic [3:0]  lo_op;
        logic        lo_cin;
        logic [31:0] hi_a;
        logic        hi_cin;
        logic        drv_zero;
        logic        ready_done;
        logic        held;
        logic        idle_after;
        logic [CNT_W-1:0] cnt_after;
    } obs_t;

    int               n_chk = 0;
    int               n_fail = 0;
    exp_t             exp_q[$];
    logic [CNT_W-1:0] exp_cnt;

    // Full-width reference: whole 64-bit (or 32-bit) arithmetic, no pass splitting.
    function automatic exp_t model(input logic [3:0] op, input logic wide,
                                   input logic [63:0] a, input logic [63:0] b, input logic cin);
        logic [64:0] s;
        logic [63:0] m;
        exp_t e;
        m = wide ? 64'hFFFF_FFFF_FFFF_FFFF : 64'h0000_0000_FFFF_FFFF;
        case (op)
            4'd0:    s = {1'b0, a & m} + {1'b0, b & m} + {64'd0, cin};
            4'd1:    s = {1'b0, a & m} - {1'b0, b & m} - {64'd0, cin};
            4'd2:    s = {1'b0, a & b};
            4'd3:    s = {1'b0, a | b};
            4'd4:    s = {1'b0, a ^ b};
            4'd5:    s = {1'b0, ~a};
            4'd6:    s = {1'b0, ~b};
            default: s = {1'b0, a};
        endcase
        e.data  = s[63:0] & m;
        e.carry = (op <= 4'd1) ? (wide ? s[64] : s[32]) : 1'b0;
        return e;
    endfunction

    // Drives one command from IDLE, records what the DUT does, then consumes the result.
    task automatic do_op(input logic [3:0] op, input logic wide, input logic [63:0] a,
                         input logic [63:0] b, input logic cin, input int hold,
                         input logic junk, output obs_t o);
        int n;
        logic [CNT_W-1:0] cnt_before;
        exp_q.push_back(model(op, wide, a, b, cin));
        @(negedge clk);
        cmd_valid = 1'b1; cmd_op = op; cmd_wide = wide; cmd_a = a; cmd_b = b; cmd_cin = cin;
        res_ready = 1'b0;
        @(negedge clk);
        n = 1;
        o.lo_a = alu_a; o.lo_op = alu_op; o.lo_cin = alu_cin;
        o.hi_a = '0; o.hi_cin = 1'b0;
        if (junk) begin
            cmd_op = 4'($urandom_range(0, 15)); cmd_wide = ~wide;
            cmd_a = {$urandom, $urandom}; cmd_b = {$urandom, $urandom}; cmd_cin = ~cin;
        end else begin
            cmd_valid = 1'b0;
        end
        while (!res_valid && n < 20) begin
            @(negedge clk);
            n++;
            if (n == 2) begin
                o.hi_a = alu_a; o.hi_cin = alu_cin;
            end
        end
        o.lat        = res_valid ? n : 99;
        o.data       = res_data;
        o.carry      = res_carry;
        o.drv_zero   = (alu_a == '0) && (alu_b == '0) && !alu_cin && (alu_op == '0);
        o.ready_done = cmd_ready;
        o.held       = 1'b1;
        cnt_before   = op_count;
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            if (res_valid !== 1'b1 || res_data !== o.data || res_carry !== o.carry ||
                cmd_ready !== 1'b0 || op_count !== cnt_before)
                o.held = 1'b0;
        end
        res_ready = 1'b1;
        @(negedge clk);
        res_ready    = 1'b0;
        cmd_valid    = 1'b0;
        o.idle_after = cmd_ready && !res_valid;
        o.cnt_after  = op_count;
        exp_cnt      = exp_cnt + CNT_W'(1);
    endtask

    task automatic test_reset();
        rst_n = 1'b0; cmd_valid = 1'b1; cmd_op = 4'd0; cmd_wide = 1'b1;
        cmd_a = '1; cmd_b = '1; cmd_cin = 1'b1; res_ready = 1'b1;
        exp_cnt = '0;
        #3;
        n_chk++; if (res_valid !== 1'b0) begin n_fail++; $display("FAIL reset_res_valid: got %b expected 0", res_valid); end
        n_chk++; if (res_data !== 64'd0) begin n_fail++; $display("FAIL reset_res_data: got %h expected 0", res_data); end
        n_chk++; if (res_carry !== 1'b0) begin n_fail++; $display("FAIL reset_res_carry: got %b expected 0", res_carry); end
        n_chk++; if (op_count !== exp_cnt) begin n_fail++; $display("FAIL reset_op_count: got %0d expected %0d", op_count, exp_cnt); end
        n_chk++; if ({alu_a, alu_b, alu_cin, alu_op} !== 69'd0) begin n_fail++; $display("FAIL reset_alu_drive: got %h expected 0", {alu_a, alu_b, alu_cin, alu_op}); end
        repeat (2) @(negedge clk);
        cmd_valid = 1'b0; res_ready = 1'b0; rst_n = 1'b1;
        @(negedge clk);
        n_chk++; if (cmd_ready !== 1'b1) begin n_fail++; $display("FAIL reset_cmd_ready: got %b expected 1", cmd_ready); end
        n_chk++; if (res_valid !== 1'b0) begin n_fail++; $display("FAIL idle_res_valid: got %b expected 0", res_valid); end
    endtask

    task automatic test_add32();
        obs_t o; exp_t e;
        do_op(4'd0, 1'b0, 64'h0000_0000_FFFF_FFFF, 64'd1, 1'b0, 0, 1'b0, o);
        e = exp_q.pop_front();
        n_chk++; if (o.data !== e.data) begin n_fail++; $display("FAIL add32_data: got %h expected %h", o.data, e.data); end
        n_chk++; if (o.carry !== e.carry) begin n_fail++; $display("FAIL add32_carry: got %b expected %b", o.carry, e.carry); end
        n_chk++; if (o.lat !== 2) begin n_fail++; $display("FAIL add32_latency: got %0d expected 2", o.lat); end
        n_chk++; if (o.lo_a !== 32'hFFFF_FFFF) begin n_fail++; $display("FAIL add32_lo_a: got %h expected ffffffff", o.lo_a); end
        n_chk++; if (o.drv_zero !== 1'b1) begin n_fail++; $display("FAIL add32_done_alu_zero: got %b expected 1", o.drv_zero); end
        n_chk++; if (o.ready_done !== 1'b0) begin n_fail++; $display("FAIL add32_cmd_ready_done: got %b expected 0", o.ready_done); end
        n_chk++; if (o.idle_after !== 1'b1) begin n_fail++; $display("FAIL add32_back_to_idle: got %b expected 1", o.idle_after); end
        n_chk++; if (o.cnt_after !== exp_cnt) begin n_fail++; $display("FAIL add32_op_count: got %0d expected %0d", o.cnt_after, exp_cnt); end
    endtask

    task automatic test_add64();
        obs_t o; exp_t e;
        do_op(4'd0, 1'b1, 64'h0000_0000_FFFF_FFFF, 64'd1, 1'b0, 0, 1'b0, o);
        e = exp_q.pop_front();
        n_chk++; if (o.data !== e.data) begin n_fail++; $display("FAIL add64_data: got %h expected %h", o.data, e.data); end
        n_chk++; if (o.carry !== e.carry) begin n_fail++; $display("FAIL add64_carry: got %b expected %b", o.carry, e.carry); end
        n_chk++; if (o.lat !== 3) begin n_fail++; $display("FAIL add64_latency: got %0d expected 3", o.lat); end
        n_chk++; if (o.hi_cin !== 1'b1) begin n_fail++; $display("FAIL add64_hi_cin: got %b expected 1", o.hi_cin); end
        n_chk++; if (o.cnt_after !== exp_cnt) begin n_fail++; $display("FAIL add64_op_count: got %0d expected %0d", o.cnt_after, exp_cnt); end
    endtask

    task automatic test_sub64();
        obs_t o; exp_t e;
        do_op(4'd1, 1'b1, 64'd0, 64'd1, 1'b0, 0, 1'b0, o);
        e = exp_q.pop_front();
        n_chk++; if (o.data !== e.data) begin n_fail++; $display("FAIL sub64_data: got %h expected %h", o.data, e.data); end
        n_chk++; if (o.carry !== e.carry) begin n_fail++; $display("FAIL sub64_borrow: got %b expected %b", o.carry, e.carry); end
        n_chk++; if (o.hi_cin !== 1'b1) begin n_fail++; $display("FAIL sub64_hi_cin: got %b expected 1", o.hi_cin); end
    endtask

    task automatic test_xor64();
        obs_t o; exp_t e;
        do_op(4'd4, 1'b1, 64'hFFFF_0000_FFFF_0000, 64'h0F0F_0F0F_0F0F_0F0F, 1'b1, 0, 1'b0, o);
        e = exp_q.pop_front();
        n_chk++; if (o.data !== e.data) begin n_fail++; $display("FAIL xor64_data: got %h expected %h", o.data, e.data); end
        n_chk++; if (o.carry !== e.carry) begin n_fail++; $display("FAIL xor64_carry: got %b expected %b", o.carry, e.carry); end
        n_chk++; if (o.hi_cin !== 1'b0) begin n_fail++; $display("FAIL xor64_hi_cin: got %b expected 0", o.hi_cin); end
    endtask

    task automatic test_random_ops();
        obs_t o; exp_t e;
        logic [3:0] op; logic wide, cin; logic [63:0] a, b;
        for (int i = 0; i < 16; i++) begin
            op = (i < 8) ? 4'(i) : 4'($urandom_range(0, 15));
            wide = 1'($urandom_range(0, 1)); cin = 1'($urandom_range(0, 1));
            a = {$urandom, $urandom}; b = {$urandom, $urandom};
            do_op(op, wide, a, b, cin, 0, 1'b0, o);
            e = exp_q.pop_front();
            n_chk++; if (o.data !== e.data) begin n_fail++; $display("FAIL rand%0d_data op=%0d w=%b: got %h expected %h", i, op, wide, o.data, e.data); end
            n_chk++; if (o.carry !== e.carry) begin n_fail++; $display("FAIL rand%0d_carry op=%0d w=%b: got %b expected %b", i, op, wide, o.carry, e.carry); end
            n_chk++; if (o.lat !== (wide ? 3 : 2)) begin n_fail++; $display("FAIL rand%0d_latency: got %0d expected %0d", i, o.lat, wide ? 3 : 2); end
            n_chk++; if (o.lo_op !== op || o.lo_a !== a[31:0] || o.lo_cin !== cin) begin n_fail++; $display("FAIL rand%0d_lo_drive: got op=%0d a=%h cin=%b expected op=%0d a=%h cin=%b", i, o.lo_op, o.lo_a, o.lo_cin, op, a[31:0], cin); end
            if (wide) begin
                n_chk++; if (o.hi_a !== a[63:32]) begin n_fail++; $display("FAIL rand%0d_hi_a: got %h expected %h", i, o.hi_a, a[63:32]); end
            end
            n_chk++; if (o.cnt_after !== exp_cnt) begin n_fail++; $display("FAIL rand%0d_op_count: got %0d expected %0d", i, o.cnt_after, exp_cnt); end
        end
    endtask

    task automatic test_backpressure();
        obs_t o; exp_t e;
        do_op(4'd0, 1'b1, 64'h1234_5678_9ABC_DEF0, 64'h0FED_CBA9_8765_4321, 1'b1, 5, 1'b0, o);
        e = exp_q.pop_front();
        n_chk++; if (o.held !== 1'b1) begin n_fail++; $display("FAIL backpressure_hold: got %b expected 1", o.held); end
        n_chk++; if (o.data !== e.data) begin n_fail++; $display("FAIL backpressure_data: got %h expected %h", o.data, e.data); end
        n_chk++; if (o.cnt_after !== exp_cnt) begin n_fail++; $display("FAIL backpressure_op_count: got %0d expected %0d", o.cnt_after, exp_cnt); end
    endtask

    task automatic test_ignore_cmd();
        obs_t o; exp_t e; logic quiet;
        do_op(4'd1, 1'b1, 64'h8000_0000_0000_0000, 64'h0000_0000_0000_0001, 1'b1, 3, 1'b1, o);
        e = exp_q.pop_front();
        n_chk++; if (o.data !== e.data) begin n_fail++; $display("FAIL ignore_data: got %h expected %h", o.data, e.data); end
        n_chk++; if (o.carry !== e.carry) begin n_fail++; $display("FAIL ignore_carry: got %b expected %b", o.carry, e.carry); end
        n_chk++; if (o.held !== 1'b1) begin n_fail++; $display("FAIL ignore_hold: got %b expected 1", o.held); end
        quiet = 1'b1;
        res_ready = 1'b1;
        repeat (4) begin
            @(negedge clk);
            if (res_valid !== 1'b0 || cmd_ready !== 1'b1) quiet = 1'b0;
        end
        res_ready = 1'b0;
        n_chk++; if (quiet !== 1'b1) begin n_fail++; $display("FAIL ignore_no_queued_cmd: got %b expected 1", quiet); end
        n_chk++; if (op_count !== exp_cnt) begin n_fail++; $display("FAIL ignore_op_count: got %0d expected %0d", op_count, exp_cnt); end
    endtask

    task automatic test_reset_in_hi();
        obs_t o; exp_t e; logic quiet;
        @(negedge clk);
        cmd_valid = 1'b1; cmd_op = 4'd0; cmd_wide = 1'b1;
        cmd_a = 64'h0000_0000_FFFF_FFFF; cmd_b = 64'd1; cmd_cin = 1'b0;
        @(negedge clk);
        cmd_valid = 1'b0;
        @(negedge clk);
        n_chk++; if (alu_cin !== 1'b1) begin n_fail++; $display("FAIL rst_hi_pass_cin: got %b expected 1", alu_cin); end
        #1 rst_n = 1'b0;
        exp_cnt = '0;
        #1;
        n_chk++; if ({alu_a, alu_b, alu_cin, alu_op} !== 69'd0) begin n_fail++; $display("FAIL rst_hi_alu_drive: got %h expected 0", {alu_a, alu_b, alu_cin, alu_op}); end
        n_chk++; if (op_count !== exp_cnt || res_data !== 64'd0) begin n_fail++; $display("FAIL rst_hi_async_clear: got count=%0d data=%h expected 0 and 0", op_count, res_data); end
        @(negedge clk);
        rst_n = 1'b1; res_ready = 1'b1;
        quiet = 1'b1;
        repeat (4) begin
            @(negedge clk);
            if (res_valid !== 1'b0 || cmd_ready !== 1'b1 || op_count !== exp_cnt) quiet = 1'b0;
        end
        res_ready = 1'b0;
        n_chk++; if (quiet !== 1'b1) begin n_fail++; $display("FAIL rst_hi_discard: got %b expected 1", quiet); end
        do_op(4'd0, 1'b1, 64'h0000_0000_FFFF_FFFF, 64'd1, 1'b0, 0, 1'b0, o);
        e = exp_q.pop_front();
        n_chk++; if (o.data !== e.data || o.carry !== e.carry) begin n_fail++; $display("FAIL rst_hi_next_op: got %h/%b expected %h/%b", o.data, o.carry, e.data, e.carry); end
        n_chk++; if (o.cnt_after !== exp_cnt) begin n_fail++; $display("FAIL rst_hi_next_count: got %0d expected %0d", o.cnt_after, exp_cnt); end
    endtask

    task automatic test_wrap();
        obs_t o; exp_t e;
        for (int i = 0; i < 4; i++) begin
            do_op(4'd3, 1'($urandom_range(0, 1)), {$urandom, $urandom}, {$urandom, $urandom}, 1'b0, 0, 1'b0, o);
            e = exp_q.pop_front();
            n_chk++; if (o.data !== e.data) begin n_fail++; $display("FAIL wrap%0d_data: got %h expected %h", i, o.data, e.data); end
            n_chk++; if (o.cnt_after !== exp_cnt) begin n_fail++; $display("FAIL wrap%0d_op_count: got %0d expected %0d", i, o.cnt_after, exp_cnt); end
        end
        n_chk++; if (op_count !== 2'd1) begin n_fail++; $display("FAIL wrap_final_count: got %0d expected 1", op_count); end
    endtask

    initial begin
        test_reset();
        test_add32();
        test_add64();
        test_sub64();
        test_xor64();
        test_random_ops();
        test_backpressure();
        test_ignore_cmd();
        test_reset_in_hi();
        test_wrap();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
